// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory-port arbiter.
`default_nettype none

package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_DM   = 1'b1;
  localparam int   LAT_W    = 4;
  localparam int   STARVE_W = 4;
endpackage

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational winner selection; ARB_RR_EN selects round-robin
// instead of fixed DM priority with an IF starvation limit.
`default_nettype none

module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                if_req_i,
  input  logic                dm_req_i,
  input  logic                owner_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                winner_o
);

`ifdef ARB_RR_EN
  logic w_unused_starve;
  assign w_unused_starve = ^starve_cnt_i;
`else
  logic w_unused_owner;
  assign w_unused_owner = owner_i;
`endif

  always_comb begin
    winner_o = OWN_IF;
    if (if_req_i && dm_req_i) begin
`ifdef ARB_RR_EN
      winner_o = ~owner_i;
`else
      winner_o = (starve_cnt_i == STARVE_W'(STARVE_MAX)) ? OWN_IF : OWN_DM;
`endif
    end else if (dm_req_i) begin
      winner_o = OWN_DM;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between 32-bit IF reads and
// 64-bit DM reads/writes. Optional macro ARB_RR_EN selects round-robin.
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  output logic        dm_done_o,
  output logic [63:0] dm_rdata_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic        mem_wr_o,
  input  logic [63:0] mem_rdata_i,
  output logic        busy_o,
  output logic        owner_o
);

  arb_state_t          state_q;
  logic                owner_q, we_q, sel_hi_q, mem_wr_q, if_done_q, dm_done_q;
  logic [LAT_W-1:0]    cnt_q;
  logic [STARVE_W-1:0] starve_q;
  logic [63:0]         mem_addr_q, mem_wdata_q, dm_rdata_q;
  logic [31:0]         if_rdata_q;
  logic                w_win, w_any, w_unused_addr;

  assign w_any         = if_req_i | dm_req_i;
  assign w_unused_addr = ^if_addr_i[1:0];

  arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req_i     (if_req_i),
    .dm_req_i     (dm_req_i),
    .owner_i      (owner_q),
    .starve_cnt_i (starve_q),
    .winner_o     (w_win)
  );

`ifdef ARB_RR_EN
  assign starve_q = '0;
`else
  logic [STARVE_W-1:0] starve_d;

  // Counts DM grants that bypassed a waiting IF; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE && w_any) begin
      if (w_win == OWN_IF)
        starve_d = '0;
      else if (if_req_i && starve_q != STARVE_W'(STARVE_MAX))
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      sel_hi_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (w_any) begin
            owner_q <= w_win;
            state_q <= ARB_ACCESS;
            cnt_q   <= LAT_W'(MEM_LAT - 1);
            if (w_win == OWN_DM) begin
              mem_addr_q  <= dm_addr_i;
              mem_wdata_q <= dm_wdata_i;
              we_q        <= dm_we_i;
              mem_wr_q    <= dm_we_i;
            end else begin
              mem_addr_q <= {if_addr_i[63:3], 3'b000};
              we_q       <= 1'b0;
              sel_hi_q   <= if_addr_i[2];
            end
          end
        end
        ARB_ACCESS: begin
          // Read data is captured on the same edge that enters RESP.
          if (we_q || cnt_q == '0) begin
            state_q <= ARB_RESP;
            if (owner_q == OWN_IF) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= sel_hi_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end else begin
              dm_done_q <= 1'b1;
              if (!we_q) dm_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wr_o    = mem_wr_q;
  assign busy_o      = (state_q != ARB_IDLE);
  assign owner_o     = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench using a MEM_LAT=1 and a MEM_LAT=3 instance.
`default_nettype none

module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst_n, a_if_req, a_if_done, a_dm_req, a_dm_we, a_dm_done, a_mem_wr, a_busy, a_owner;
  logic [63:0] a_if_addr, a_dm_addr, a_dm_wdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata;
  logic        b_rst_n, b_if_req, b_if_done, b_dm_req, b_dm_we, b_dm_done, b_mem_wr, b_busy, b_owner;
  logic [63:0] b_if_addr, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata;

  function automatic logic [63:0] mem_fn(input logic [63:0] addr);
    case (addr)
      64'h08:  return 64'h1122334455667788;
      64'h200: return 64'h000000000000A5A5;
      default: return {~addr[31:0], addr[31:0]};
    endcase
  endfunction

  assign a_mem_rdata = mem_fn(a_mem_addr);
  assign b_mem_rdata = mem_fn(b_mem_addr);

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_done_o(a_if_done), .if_rdata_o(a_if_rdata),
    .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_addr_i(a_dm_addr), .dm_wdata_i(a_dm_wdata),
    .dm_done_o(a_dm_done), .dm_rdata_o(a_dm_rdata),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_wr_o(a_mem_wr), .mem_rdata_i(a_mem_rdata),
    .busy_o(a_busy), .owner_o(a_owner)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_done_o(b_if_done), .if_rdata_o(b_if_rdata),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
    .dm_done_o(b_dm_done), .dm_rdata_o(b_dm_rdata),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_wr_o(b_mem_wr), .mem_rdata_i(b_mem_rdata),
    .busy_o(b_busy), .owner_o(b_owner)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_if_req = 0; a_dm_req = 0; a_dm_we = 0; a_if_addr = '0; a_dm_addr = '0; a_dm_wdata = '0;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0; b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0;
    cyc(); cyc();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    cyc();
    checks++; if ({a_busy, a_owner, a_mem_wr, a_if_done, a_dm_done} !== 5'b0) begin errors++; $display("FAIL reset_ctrl_a: got %b expected 00000", {a_busy, a_owner, a_mem_wr, a_if_done, a_dm_done}); end
    checks++; if ({a_mem_addr, a_mem_wdata, a_dm_rdata, a_if_rdata} !== '0) begin errors++; $display("FAIL reset_data_a: got %h %h %h %h expected 0", a_mem_addr, a_mem_wdata, a_dm_rdata, a_if_rdata); end
    checks++; if ({b_busy, b_owner, b_mem_wr, b_if_done, b_dm_done} !== 5'b0) begin errors++; $display("FAIL reset_ctrl_b: got %b expected 00000", {b_busy, b_owner, b_mem_wr, b_if_done, b_dm_done}); end
  endtask

  task automatic test_if_read(input logic [63:0] addr, input logic [63:0] exp_maddr, input logic [31:0] exp_word);
    a_if_addr = addr; a_if_req = 1'b1;
    cyc();
    checks++; if (a_mem_addr !== exp_maddr) begin errors++; $display("FAIL if_mem_addr: got %h expected %h", a_mem_addr, exp_maddr); end
    checks++; if ({a_busy, a_owner, a_mem_wr, a_if_done} !== 4'b1000) begin errors++; $display("FAIL if_access_ctrl: got %b expected 1000", {a_busy, a_owner, a_mem_wr, a_if_done}); end
    cyc();
    checks++; if ({a_if_done, a_dm_done} !== 2'b10) begin errors++; $display("FAIL if_done_pulse: got %b expected 10", {a_if_done, a_dm_done}); end
    checks++; if (a_if_rdata !== exp_word) begin errors++; $display("FAIL if_rdata: got %h expected %h", a_if_rdata, exp_word); end
    a_if_req = 1'b0;
    cyc();
    checks++; if ({a_if_done, a_busy} !== 2'b00) begin errors++; $display("FAIL if_after_done: got %b expected 00", {a_if_done, a_busy}); end
    checks++; if (a_if_rdata !== exp_word) begin errors++; $display("FAIL if_rdata_hold: got %h expected %h", a_if_rdata, exp_word); end
  endtask

  task automatic test_dm_write();
    a_dm_addr = 64'h100; a_dm_wdata = 64'hDEADBEEF00000001; a_dm_we = 1'b1; a_dm_req = 1'b1;
    cyc();
    checks++; if ({a_mem_wr, a_owner, a_dm_done, a_if_done} !== 4'b1100) begin errors++; $display("FAIL wr_access_ctrl: got %b expected 1100", {a_mem_wr, a_owner, a_dm_done, a_if_done}); end
    checks++; if (a_mem_addr !== 64'h100 || a_mem_wdata !== 64'hDEADBEEF00000001) begin errors++; $display("FAIL wr_addr_data: got %h %h expected 100 deadbeef00000001", a_mem_addr, a_mem_wdata); end
    cyc();
    checks++; if ({a_mem_wr, a_dm_done, a_if_done} !== 3'b010) begin errors++; $display("FAIL wr_done: got %b expected 010", {a_mem_wr, a_dm_done, a_if_done}); end
    checks++; if (a_dm_rdata !== 64'h0) begin errors++; $display("FAIL wr_rdata_unchanged: got %h expected 0", a_dm_rdata); end
    a_dm_req = 1'b0; a_dm_we = 1'b0;
    cyc();
    checks++; if ({a_mem_wr, a_dm_done, a_if_done, a_busy} !== 4'b0000) begin errors++; $display("FAIL wr_idle_ctrl: got %b expected 0000", {a_mem_wr, a_dm_done, a_if_done, a_busy}); end
    checks++; if (a_mem_addr !== 64'h100) begin errors++; $display("FAIL wr_addr_hold: got %h expected 100", a_mem_addr); end
  endtask

  task automatic test_starvation();
    logic exp_v [6];
    int seen = 0;
`ifdef ARB_RR_EN
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    a_rst_n = 1'b0;
    cyc();
    a_rst_n = 1'b1;
    a_if_addr = 64'h10; a_dm_addr = 64'h40; a_dm_we = 1'b0;
    a_if_req = 1'b1; a_dm_req = 1'b1;
    for (int c = 0; c < 60 && seen < 6; c++) begin
      cyc();
      if (a_if_done || a_dm_done) begin
        checks++;
        if (a_owner !== exp_v[seen] || a_dm_done !== exp_v[seen] || a_if_done !== !exp_v[seen]) begin
          errors++;
          $display("FAIL grant_%0d: got owner=%b if_done=%b dm_done=%b expected owner=%b", seen, a_owner, a_if_done, a_dm_done, exp_v[seen]);
        end
        seen++;
        if (seen == 6) begin a_if_req = 1'b0; a_dm_req = 1'b0; end
      end
    end
    checks++; if (seen != 6) begin errors++; $display("FAIL grant_count: got %0d expected 6", seen); end
    cyc();
  endtask

  task automatic test_lat3_read();
    b_dm_addr = 64'h200; b_dm_we = 1'b0; b_dm_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++; if (b_busy !== 1'b1 || b_dm_done !== (c == 4)) begin errors++; $display("FAIL lat3_cycle%0d: got busy=%b done=%b expected busy=1 done=%b", c, b_busy, b_dm_done, (c == 4)); end
    end
    checks++; if (b_dm_rdata !== 64'hA5A5) begin errors++; $display("FAIL lat3_rdata: got %h expected a5a5", b_dm_rdata); end
    b_dm_req = 1'b0;
    cyc();
    checks++; if ({b_busy, b_dm_done} !== 2'b00) begin errors++; $display("FAIL lat3_idle: got %b expected 00", {b_busy, b_dm_done}); end
  endtask

  task automatic test_reset_mid();
    b_dm_addr = 64'h200; b_dm_we = 1'b0; b_dm_req = 1'b1;
    cyc(); cyc();
    b_rst_n = 1'b0;
    #1;
    checks++; if ({b_busy, b_owner, b_mem_wr, b_dm_done, b_if_done} !== 5'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 00000", {b_busy, b_owner, b_mem_wr, b_dm_done, b_if_done}); end
    checks++; if (b_mem_addr !== 64'h0 || b_dm_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_data: got %h %h expected 0 0", b_mem_addr, b_dm_rdata); end
    cyc();
    checks++; if (b_dm_done !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rstmid_held: got done=%b busy=%b expected 0 0", b_dm_done, b_busy); end
    b_rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      checks++; if (b_dm_done !== (c == 4)) begin errors++; $display("FAIL rstmid_retry_cycle%0d: got done=%b expected %b", c, b_dm_done, (c == 4)); end
    end
    checks++; if (b_dm_rdata !== 64'hA5A5) begin errors++; $display("FAIL rstmid_rdata: got %h expected a5a5", b_dm_rdata); end
    b_dm_req = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_if_read(64'h0C, 64'h08, 32'h11223344);
    test_if_read(64'h08, 64'h08, 32'h55667788);
    test_dm_write();
    test_starvation();
    test_lat3_read();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
